// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit
//
// Multicycle control unit. It accepts one opcode through a valid/ready
// handshake and steps it through DECODE, EXEC, optionally MEM, then WB,
// driving the datapath control strobes for each phase. During MEM it waits
// on the data memory's mem_ready, with an optional timeout that parks the
// block in a sticky ERR state. It also counts retired instructions.
//
// Handshake: an instruction is transferred at a rising edge where
// instr_valid and instr_ready are both 1. instr_ready is 1 only in IDLE,
// and opco is sampled only at that edge. instr_valid and opco are ignored
// in every other state.
//
// Ports:
//   clk                 clock, rising edge
//   rst_n               synchronous reset, active low
//   opco                instruction opcode (OPCODE_W)
//   instr_valid         opco is valid
//   instr_ready         block is idle and can accept an instruction
//   mem_ready           data memory has completed the current access
//   regDestination      destination register select (add/sll)
//   sourceALU           ALU B-operand select (add)
//   alu_opcode          captured opcode forwarded to the ALU
//   memory_read         data memory read strobe (lw, MEM state)
//   memoryWrite         data memory write strobe (sw, MEM state)
//   memory_to_register  writeback mux selects memory data (lw)
//   register_write      register file write enable (WB, all but sw)
//   done                one-cycle pulse when an instruction retires
//   mem_error           sticky memory-timeout flag
//   retire_count        retired-instruction counter (CNT_W, wraps)
//   state_dbg           current FSM state encoding, for observation
module multicycle_ctrl_unit #(
    parameter int                     OPCODE_W    = 3,
    parameter logic [OPCODE_W-1:0]    OP_ADD      = OPCODE_W'(3'b000),
    parameter logic [OPCODE_W-1:0]    OP_SW       = OPCODE_W'(3'b101),
    parameter logic [OPCODE_W-1:0]    OP_LW       = OPCODE_W'(3'b110),
    parameter logic [OPCODE_W-1:0]    OP_SLL      = OPCODE_W'(3'b111),
    parameter int                     MEM_TIMEOUT = 8,
    parameter int                     CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opco,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                mem_ready,
    output logic                regDestination,
    output logic                sourceALU,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic                memory_read,
    output logic                memoryWrite,
    output logic                memory_to_register,
    output logic                register_write,
    output logic                done,
    output logic                mem_error,
    output logic [CNT_W-1:0]    retire_count,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // The wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

    state_t              state;
    state_t              state_nxt;
    logic [OPCODE_W-1:0] op_q;
    logic [WAIT_W-1:0]   wait_cnt;

    logic is_add;
    logic is_sw;
    logic is_lw;
    logic is_sll;
    logic active;

    // Decode flags come from the captured opcode, never from opco, so
    // every output stays a function of registered state.
    assign is_add = (op_q == OP_ADD);
    assign is_sw  = (op_q == OP_SW);
    assign is_lw  = (op_q == OP_LW);
    assign is_sll = (op_q == OP_SLL);

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= '0;
            wait_cnt     <= '0;
            retire_count <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && instr_valid) begin
                op_q <= opco;
            end

            // EXEC is the only way into MEM, so clearing here gives a
            // fresh count on every MEM entry.
            if (state == S_EXEC) begin
                wait_cnt <= '0;
            end else if (state == S_MEM && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (state == S_WB) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                // mem_ready wins over a timeout on the same edge.
                if (mem_ready) begin
                    state_nxt = S_WB;
                end else if (TIMEOUT_EN && wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_WB:    state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready        = 1'b0;
        regDestination     = 1'b0;
        sourceALU          = 1'b0;
        alu_opcode         = '0;
        memory_read        = 1'b0;
        memoryWrite        = 1'b0;
        memory_to_register = 1'b0;
        register_write     = 1'b0;
        done               = 1'b0;
        mem_error          = 1'b0;
        active             = 1'b0;

        unique case (state)
            S_IDLE: instr_ready = 1'b1;
            S_DECODE, S_EXEC: active = 1'b1;
            S_MEM: begin
                active      = 1'b1;
                memory_read = is_lw;
                memoryWrite = is_sw;
            end
            S_WB: begin
                active         = 1'b1;
                register_write = !is_sw;
                done           = 1'b1;
            end
            S_ERR: mem_error = 1'b1;
            default: instr_ready = 1'b0;
        endcase

        // Static controls hold from DECODE through WB.
        if (active) begin
            alu_opcode         = op_q;
            sourceALU          = is_add;
            regDestination     = is_add || is_sll;
            memory_to_register = is_lw;
        end
    end

endmodule
